// File: rtl/exec_pkg.sv
// exec_pkg: shared execute-stage widths, source ids and result payload
package exec_pkg;
    localparam int DATA_W = 16;
    localparam int TAG_W  = 5;
    typedef enum logic [1:0] {SRC_A0, SRC_A1, SRC_M, SRC_LS} src_e;
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } result_t;
    localparam logic [TAG_W-1:0] NO_TAG = '0;
endpackage

// File: rtl/result_fifo.sv
// result_fifo: small per-unit result buffer with flush; full/empty from occupancy only
module result_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = exec_pkg::result_t
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic push,
    input  logic pop,
    input  T     push_data,
    output logic full,
    output logic empty,
    output T     head
);
    localparam int AW = $clog2(DEPTH);
    T               mem_q [DEPTH];
    logic [AW-1:0]  wr_q, rd_q;
    logic [AW:0]    cnt_q, cnt_d;
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign head  = mem_q[rd_q];
    assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem_q[wr_q] <= push_data;
    end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: buffers four execution-unit results and round-robins them onto
// the registered result broadcast bus
module writeback_arbiter
    import exec_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              a0_valid,
    input  logic              a1_valid,
    input  logic              m_valid,
    input  logic              ls_valid,
    input  logic [DATA_W-1:0] a0_data,
    input  logic [DATA_W-1:0] a1_data,
    input  logic [DATA_W-1:0] m_data,
    input  logic [7:0]        ls_data,
    input  logic [TAG_W-1:0]  a0_tag,
    input  logic [TAG_W-1:0]  a1_tag,
    input  logic [TAG_W-1:0]  m_tag,
    input  logic [TAG_W-1:0]  ls_tag,
    output logic              a0_ready,
    output logic              a1_ready,
    output logic              m_ready,
    output logic              ls_ready,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic [1:0]        cdb_src
);
    logic [3:0] valid, full, empty, push, pop;
    result_t    in_r [4];
    result_t    head [4];
    logic       gnt_vld;
    logic [1:0] gnt_idx, rr_q;
    logic       vld_q;
    result_t    cdb_q;
    src_e       src_q;
    assign valid = {ls_valid, m_valid, a1_valid, a0_valid};
    assign in_r[0] = '{tag: a0_tag, data: a0_data};
    assign in_r[1] = '{tag: a1_tag, data: a1_data};
    assign in_r[2] = '{tag: m_tag,  data: m_data};
    assign in_r[3] = '{tag: ls_tag, data: DATA_W'(ls_data)};
    assign {ls_ready, m_ready, a1_ready, a0_ready} = ~full;
    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_fifo
            // tag 0 completes the handshake but is never buffered
            assign push[g] = valid[g] && !full[g] && in_r[g].tag != NO_TAG;
            assign pop[g]  = gnt_vld && gnt_idx == 2'(g);
            result_fifo #(.DEPTH(DEPTH), .T(result_t)) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush),
                .push      (push[g]),
                .pop       (pop[g]),
                .push_data (in_r[g]),
                .full      (full[g]),
                .empty     (empty[g]),
                .head      (head[g])
            );
        end
    endgenerate
    // descending scan so the candidate nearest rr_q is the one that sticks
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rr_q;
        for (int i = 3; i >= 0; i--) begin
            if (!empty[rr_q + 2'(i)]) begin
                gnt_vld = !flush;
                gnt_idx = rr_q + 2'(i);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q  <= '0;
            vld_q <= 1'b0;
            cdb_q <= '0;
            src_q <= SRC_A0;
        end else begin
            vld_q <= gnt_vld;
            if (gnt_vld) begin
                rr_q  <= gnt_idx + 2'd1;
                cdb_q <= head[gnt_idx];
                src_q <= src_e'(gnt_idx);
            end
        end
    end
    assign cdb_valid = vld_q;
    assign cdb_tag   = cdb_q.tag;
    assign cdb_data  = cdb_q.data;
    assign cdb_src   = src_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: queue-model checked random and directed stimulus for writeback_arbiter
module tb_writeback_arbiter;
    import exec_pkg::*;
    localparam int DEPTH = 2;
    logic clk = 0, rst = 1, flush = 0;
    logic              vld [4];
    logic [TAG_W-1:0]  tg  [4];
    logic [DATA_W-1:0] dt  [4];
    logic a0_ready, a1_ready, m_ready, ls_ready, cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic [1:0]        cdb_src;
    logic [3:0]        rdy;
    assign rdy = {ls_ready, m_ready, a1_ready, a0_ready};
    always #5 clk = ~clk;

    writeback_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .a0_valid(vld[0]), .a1_valid(vld[1]), .m_valid(vld[2]), .ls_valid(vld[3]),
        .a0_data(dt[0]), .a1_data(dt[1]), .m_data(dt[2]), .ls_data(dt[3][7:0]),
        .a0_tag(tg[0]), .a1_tag(tg[1]), .m_tag(tg[2]), .ls_tag(tg[3]),
        .a0_ready(a0_ready), .a1_ready(a1_ready), .m_ready(m_ready), .ls_ready(ls_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
    );

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference: one queue per source, round-robin pointer, expected broadcast register
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } ent_t;
    ent_t mq [4][$];
    int rr = 0;
    bit live = 0;
    logic              e_v = 0;
    logic [TAG_W-1:0]  e_tag = 0;
    logic [DATA_W-1:0] e_data = 0;
    logic [1:0]        e_src = 0;

    always @(posedge clk) begin
        int g;
        bit can [4];
        ent_t e;
        live = 1;
        if (rst) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            rr = 0; e_v = 0; e_tag = 0; e_data = 0; e_src = 0;
        end else if (flush) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            e_v = 0;
        end else begin
            for (int i = 0; i < 4; i++) can[i] = mq[i].size() < DEPTH;
            g = -1;
            for (int k = 0; k < 4; k++)
                if (g < 0 && mq[(rr + k) % 4].size() > 0) g = (rr + k) % 4;
            e_v = (g >= 0);
            if (g >= 0) begin
                e = mq[g].pop_front();
                e_tag = e.tag; e_data = e.data; e_src = 2'(g);
                rr = (g + 1) % 4;
            end
            for (int i = 0; i < 4; i++)
                if (vld[i] && can[i] && tg[i] != 0)
                    mq[i].push_back('{tag: tg[i], data: (i == 3) ? (dt[i] & 16'h00FF) : dt[i]});
        end
    end

    always @(negedge clk) begin
        if (live) begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("ready%0d", i), 32'(rdy[i]), 32'(mq[i].size() < DEPTH));
            chk("cdb_valid", 32'(cdb_valid), 32'(e_v));
            chk("cdb_tag", 32'(cdb_tag), 32'(e_tag));
            chk("cdb_data", 32'(cdb_data), 32'(e_data));
            chk("cdb_src", 32'(cdb_src), 32'(e_src));
        end
    end

    task automatic idle();
        for (int i = 0; i < 4; i++) begin
            vld[i] = 0; tg[i] = 0; dt[i] = 0;
        end
    endtask
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask
    task automatic put(input int s, input int t, input int d);
        vld[s] = 1; tg[s] = TAG_W'(t); dt[s] = DATA_W'(d);
    endtask
    task automatic pulse_rst();
        rst = 1; step(); rst = 0;
    endtask

    initial begin
        idle();
        step(2);
        rst = 0;
        step();
        chk("rst_a0_ready", 32'(a0_ready), 1);
        chk("rst_ls_ready", 32'(ls_ready), 1);
        chk("rst_cdb_valid", 32'(cdb_valid), 0);
        chk("rst_cdb_tag", 32'(cdb_tag), 0);
        // single push, two-cycle latency
        put(0, 3, 'h1234); step(); idle(); step();
        chk("lat_valid", 32'(cdb_valid), 1);
        chk("lat_tag", 32'(cdb_tag), 3);
        chk("lat_data", 32'(cdb_data), 'h1234);
        chk("lat_src", 32'(cdb_src), 0);
        step();
        chk("lat_idle", 32'(cdb_valid), 0);
        // all four at once from rr=0
        pulse_rst();
        for (int i = 0; i < 4; i++) put(i, i + 1, 'h100 + i);
        step(); idle();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("order_src", 32'(cdb_src), 32'(k));
            chk("order_tag", 32'(cdb_tag), 32'(k + 1));
        end
        // wrap: A1 before LS
        put(1, 5, 'h55); put(3, 6, 'h66); step(); idle(); step();
        chk("wrap_first", 32'(cdb_src), 1);
        step();
        chk("wrap_second", 32'(cdb_src), 3);
        chk("wrap_ls_data", 32'(cdb_data), 'h0066);
        step();
        chk("wrap_idle", 32'(cdb_valid), 0);
        // M fills under contention; rejected push never appears
        pulse_rst();
        put(0, 1, 1); put(1, 2, 2); put(2, 8, 'h80); put(3, 4, 4);
        step();
        put(2, 10, 'hA0);
        step();
        chk("m_full", 32'(m_ready), 0);
        idle(); put(2, 9, 'hDEAD);
        step();
        chk("m_still_full", 32'(m_ready), 0);
        idle();
        step();
        chk("m_pop_src", 32'(cdb_src), 2);
        chk("m_pop_tag", 32'(cdb_tag), 8);
        chk("m_ready_back", 32'(m_ready), 1);
        step(6);
        // load byte zero-extension, tag-0 push
        put(3, 7, 'hAB); step(); idle(); step();
        chk("ls_zext", 32'(cdb_data), 'h00AB);
        chk("ls_tag", 32'(cdb_tag), 7);
        put(0, 0, 'hBEEF); step(); idle(); step(3);
        chk("tag0_none", 32'(cdb_valid), 0);
        // flush with buffered results and a concurrent push
        put(0, 11, 1); put(1, 12, 2); put(2, 13, 3); step(); idle();
        flush = 1; put(3, 14, 4); step(); flush = 0; idle();
        chk("flush_valid", 32'(cdb_valid), 0);
        chk("flush_ready", 32'(a1_ready), 1);
        step(3);
        chk("flush_stale", 32'(cdb_valid), 0);
        // randomized traffic with sparse flush and reset
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                vld[i] = ($urandom_range(0, 3) < ((n / 500) % 2 ? 3 : 1));
                tg[i]  = TAG_W'($urandom_range(0, 31));
                dt[i]  = DATA_W'($urandom);
            end
            flush = ($urandom_range(0, 40) == 0);
            rst   = ($urandom_range(0, 150) == 0);
            step();
        end
        rst = 0; flush = 0; idle();
        step(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
